// File: rtl/modport_dut.sv
// APB slave UART: 32-bit register interface in front of an 8N1 transmitter and receiver.
// The bit period comes from BAUD, and loopback routes TX into RX internally.
module modport_dut (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        uart_txd,
    input  logic        uart_rxd
);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic        acc, wr, rd;
    logic [7:0]  addr;
    logic [15:0] baud, period;
    logic [2:0]  ctrl;
    logic [7:0]  rx_data;
    logic        rx_valid, overrun, frame_err;
    logic        unused_bits;

    tx_state_t   tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_cnt_n;
    logic [7:0]  tx_sh, tx_sh_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic        tx_line, tx_busy;

    rx_state_t   rx_state, rx_state_n;
    logic [15:0] rx_cnt, rx_cnt_n;
    logic [7:0]  rx_sh, rx_sh_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic        rx_sync1, rx_sync2, rx_prev, rx_src, rx_fall, rx_done;

    assign acc         = psel & penable;
    assign wr          = acc & pwrite;
    assign rd          = acc & ~pwrite;
    assign addr        = paddr[7:0];
    assign pready      = 1'b1;
    assign unused_bits = ^{paddr[31:8], pwdata[31:16]};

    // Each counter reloads from this at every bit boundary, so BAUD writes apply from the next bit.
    assign period   = (baud < 16'd4) ? 16'd4 : baud;
    assign tx_busy  = (tx_state != TX_IDLE);
    assign uart_txd = ctrl[2] | tx_line;
    assign rx_src   = ctrl[2] ? tx_line : rx_sync2;
    assign rx_fall  = rx_prev & ~rx_src;
    assign rx_done  = (rx_state == RX_STOP) && (rx_cnt == '0);

    always_comb begin
        prdata = '0;
        if (rd) begin
            case (addr)
                8'h04:   prdata[7:0]  = rx_data;
                8'h08:   prdata[3:0]  = {frame_err, overrun, rx_valid, tx_busy};
                8'h0C:   prdata[15:0] = baud;
                8'h10:   prdata[2:0]  = ctrl;
                default: prdata       = '0;
            endcase
        end
    end

    always_comb begin
        case (tx_state)
            TX_START: tx_line = 1'b0;
            TX_DATA:  tx_line = tx_sh[0];
            default:  tx_line = 1'b1;
        endcase
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_sh_n    = tx_sh;
        tx_bit_n   = tx_bit;
        case (tx_state)
            TX_IDLE: begin
                if (wr && addr == 8'h00 && ctrl[0]) begin
                    tx_state_n = TX_START;
                    tx_cnt_n   = period - 16'd1;
                    tx_sh_n    = pwdata[7:0];
                end
            end
            TX_START: begin
                if (tx_cnt == '0) begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = period - 16'd1;
                    tx_bit_n   = '0;
                end else begin
                    tx_cnt_n = tx_cnt - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt == '0) begin
                    tx_cnt_n = period - 16'd1;
                    tx_sh_n  = {1'b0, tx_sh[7:1]};
                    if (tx_bit == 3'd7) tx_state_n = TX_STOP;
                    else                tx_bit_n   = tx_bit + 3'd1;
                end else begin
                    tx_cnt_n = tx_cnt - 16'd1;
                end
            end
            default: begin
                if (tx_cnt == '0) tx_state_n = TX_IDLE;
                else              tx_cnt_n   = tx_cnt - 16'd1;
            end
        endcase
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_sh_n    = rx_sh;
        rx_bit_n   = rx_bit;
        case (rx_state)
            RX_IDLE: begin
                if (ctrl[1] && rx_fall) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = (period >> 1) - 16'd1;
                end
            end
            RX_START: begin
                if (rx_cnt == '0) begin
                    rx_state_n = rx_src ? RX_IDLE : RX_DATA;
                    rx_cnt_n   = period - 16'd1;
                    rx_bit_n   = '0;
                end else begin
                    rx_cnt_n = rx_cnt - 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == '0) begin
                    rx_cnt_n = period - 16'd1;
                    rx_sh_n  = {rx_src, rx_sh[7:1]};
                    if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                    else                rx_bit_n   = rx_bit + 3'd1;
                end else begin
                    rx_cnt_n = rx_cnt - 16'd1;
                end
            end
            default: begin
                if (rx_cnt == '0) rx_state_n = RX_IDLE;
                else              rx_cnt_n   = rx_cnt - 16'd1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_sh    <= '0;
            tx_bit   <= '0;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_sh    <= '0;
            rx_bit   <= '0;
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
            rx_prev  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_sh    <= tx_sh_n;
            tx_bit   <= tx_bit_n;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_sh    <= rx_sh_n;
            rx_bit   <= rx_bit_n;
            rx_sync1 <= uart_rxd;
            rx_sync2 <= rx_sync1;
            rx_prev  <= rx_src;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud      <= 16'd16;
            ctrl      <= 3'b011;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (wr && addr == 8'h0C) baud <= pwdata[15:0];
            if (wr && addr == 8'h10) ctrl <= pwdata[2:0];
            if (wr && addr == 8'h08) begin
                if (pwdata[2]) overrun   <= 1'b0;
                if (pwdata[3]) frame_err <= 1'b0;
            end
            if (rd && addr == 8'h04) rx_valid <= 1'b0;
            // A completion on the same edge as an RXDATA read keeps rx_valid and is not an overrun.
            if (rx_done) begin
                rx_data  <= rx_sh;
                rx_valid <= 1'b1;
                if (!rx_src) frame_err <= 1'b1;
                if (rx_valid && !(rd && addr == 8'h04)) overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_modport_dut.sv
// Scoreboard bench for modport_dut: APB reads and TX frames are checked by monitors
// against expectations queued by the directed stimulus.
module tb_modport_dut;

    logic        clk, rst;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready, uart_txd, uart_rxd;

    int total = 0;
    int bad   = 0;
    int tb_baud = 16;
    logic mon_on = 1'b0;

    logic [31:0] exp_q[$];
    string       nm_q[$];
    logic [7:0]  tx_q[$];

    modport_dut dut (
        .clk(clk), .rst(rst), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .uart_txd(uart_txd), .uart_rxd(uart_rxd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // APB read monitor: compares prdata during each read access phase.
    always @(negedge clk) begin
        if (psel && penable && !pwrite && exp_q.size() > 0) begin
            chk(nm_q.pop_front(), prdata, exp_q.pop_front());
        end
    end

    // TX monitor: every start bit on uart_txd must match a queued byte.
    initial begin
        logic [7:0] b;
        logic [9:0] frame;
        forever begin
            @(negedge uart_txd);
            if (mon_on && !rst) begin
                if (tx_q.size() == 0) begin
                    chk("tx_spurious_start", {31'b0, uart_txd}, 32'd1);
                end else begin
                    b = tx_q.pop_front();
                    frame = {1'b1, b, 1'b0};
                    repeat (tb_baud / 2) @(negedge clk);
                    for (int i = 0; i < 10; i++) begin
                        chk($sformatf("tx_%0h_bit%0d", b, i), {31'b0, uart_txd}, {31'b0, frame[i]});
                        if (i < 9) repeat (tb_baud) @(negedge clk);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        paddr = {24'hA5A5A5, a}; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, input logic [31:0] e, input string n);
        exp_q.push_back(e);
        nm_q.push_back(n);
        paddr = {24'h00FF00, a}; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit);
        uart_rxd = 1'b0;
        cyc(8);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            cyc(8);
        end
        uart_rxd = stop_bit;
        cyc(8);
        uart_rxd = 1'b1;
        cyc(4);
    endtask

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; uart_rxd = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pready", {31'b0, pready}, 32'd1);
        chk("rst_txd", {31'b0, uart_txd}, 32'd1);
        chk("rst_prdata", prdata, 32'd0);
        @(posedge clk); #1 rst = 1'b0; mon_on = 1'b1;
        cyc(2);

        apb_read(8'h08, 32'h0, "rst_status");
        apb_read(8'h0C, 32'h10, "rst_baud");
        apb_read(8'h10, 32'h3, "rst_ctrl");
        apb_read(8'h04, 32'h0, "rst_rxdata");
        apb_read(8'h40, 32'h0, "unmapped_40");
        apb_read(8'h00, 32'h0, "txdata_read");

        // 0xA5 at BAUD=16; busy must drop exactly 160 cycles after the start bit appears.
        tb_baud = 16;
        tx_q.push_back(8'hA5);
        apb_write(8'h00, 32'hA5);
        cyc(157);
        apb_read(8'h08, 32'h1, "busy_last_cycle");
        apb_read(8'h08, 32'h0, "busy_cleared");

        tx_q.push_back(8'h5A);
        apb_write(8'h00, 32'h5A);
        cyc(30);
        apb_write(8'h00, 32'hFF);
        cyc(150);
        apb_read(8'h08, 32'h0, "status_after_ignored_write");

        apb_write(8'h0C, 32'h2);
        apb_read(8'h0C, 32'h2, "baud_readback_2");
        tb_baud = 4;
        tx_q.push_back(8'h96);
        apb_write(8'h00, 32'h96);
        cyc(50);
        apb_read(8'h08, 32'h0, "status_after_min_baud");

        apb_write(8'h0C, 32'h8);
        apb_write(8'h10, 32'h7);
        apb_read(8'h10, 32'h7, "ctrl_loopback");
        apb_write(8'h00, 32'h3C);
        cyc(100);
        apb_read(8'h08, 32'h2, "lb_status_valid");
        apb_read(8'h04, 32'h3C, "lb_rxdata");
        apb_read(8'h08, 32'h0, "lb_status_cleared");

        apb_write(8'h10, 32'h3);
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        cyc(10);
        apb_read(8'h08, 32'h6, "overrun_status");
        apb_write(8'h08, 32'h4);
        apb_read(8'h08, 32'h2, "overrun_w1c");
        apb_read(8'h04, 32'h22, "overrun_rxdata");
        apb_read(8'h08, 32'h0, "overrun_final");

        send(8'h55, 1'b0);
        cyc(10);
        apb_read(8'h08, 32'hA, "frame_err_status");
        apb_read(8'h04, 32'h55, "frame_err_rxdata");
        apb_write(8'h08, 32'h8);
        apb_read(8'h08, 32'h0, "frame_err_w1c");

        uart_rxd = 1'b0;
        cyc(1);
        uart_rxd = 1'b1;
        cyc(40);
        apb_read(8'h08, 32'h0, "glitch_ignored");

        apb_write(8'h10, 32'h0);
        apb_write(8'h00, 32'h81);
        cyc(30);
        chk("ctrl0_txd_idle", {31'b0, uart_txd}, 32'd1);
        apb_read(8'h08, 32'h0, "ctrl0_not_busy");

        cyc(20);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("tx_queue_drained", 32'(tx_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
